// File: rtl/lcd_fb_pkg.sv
// lcd_fb_pkg: shared grant encoding, read latency and default widths for the frame-buffer arbiter
package lcd_fb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } grant_e;

    localparam int RD_LAT = 3;
    localparam int AW_DEF = 16;
    localparam int DW_DEF = 16;

endpackage

// File: rtl/lcd_fb_wfifo.sv
// lcd_fb_wfifo: posted-write FIFO holding {addr, data} pairs until the RAM is free
module lcd_fb_wfifo
    import lcd_fb_pkg::*;
#(
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rest_n,
    input  logic                     push,
    input  logic [AW-1:0]            in_addr,
    input  logic [DW-1:0]            in_data,
    input  logic                     pop,
    output logic [AW-1:0]            head_addr,
    output logic [DW-1:0]            head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] addr_mem [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];
    logic [PW-1:0] wp;
    logic [PW-1:0] rp;

    assign head_addr = addr_mem[rp];
    assign head_data = data_mem[rp];
    assign full      = count == CW'(DEPTH);
    assign empty     = count == '0;

    // entry storage, written at the tail on every accepted push
    always_ff @(posedge clk or negedge rest_n) begin
        if (!rest_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem[i] <= '0;
                data_mem[i] <= '0;
            end
        end else if (push) begin
            addr_mem[wp] <= in_addr;
            data_mem[wp] <= in_data;
        end
    end

    // pointers wrap naturally at DEPTH; count tracks occupancy including same-edge push+pop
    always_ff @(posedge clk or negedge rest_n) begin
        if (!rest_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push)
                wp <= wp + PW'(1);
            if (pop)
                rp <= rp + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: rtl/lcd_fb_arbiter.sv
// lcd_fb_arbiter: single-port frame-buffer RAM shared by LCD scan-out (priority) and a posted pixel writer
// Optional build macro LCD_FB_ARB_STAT_EN adds the wr_stall_cnt saturating stall counter.
module lcd_fb_arbiter
    import lcd_fb_pkg::*;
#(
    parameter int AW          = AW_DEF,
    parameter int DW          = DW_DEF,
    parameter int WFIFO_DEPTH = 8
) (
    input  logic          clk,
    input  logic          rest_n,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_wdat,
    input  logic [DW-1:0] ram_rdat
`ifdef LCD_FB_ARB_STAT_EN
    ,
    output logic [15:0]   wr_stall_cnt
`endif
);

    localparam int CW = $clog2(WFIFO_DEPTH) + 1;

    grant_e        state_q;
    grant_e        grant;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          pending;
    logic          push;
    logic          pop;
    logic [AW-1:0] head_addr;
    logic [DW-1:0] head_data;
    logic [AW-1:0] rd_addr_q;
    logic [RD_LAT-2:0] rd_pipe;

    assign wr_ready = !full;
    assign push     = wr_valid && wr_ready;
    assign pop      = state_q == WR;
    // the head granted last edge is popped this edge, so it no longer counts as pending work
    assign pending  = !empty && (state_q != WR || count > CW'(1));

    lcd_fb_wfifo #(
        .AW    (AW),
        .DW    (DW),
        .DEPTH (WFIFO_DEPTH)
    ) u_wfifo (
        .clk       (clk),
        .rest_n    (rest_n),
        .push      (push),
        .in_addr   (wr_addr),
        .in_data   (wr_data),
        .pop       (pop),
        .head_addr (head_addr),
        .head_data (head_data),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    // grant register: scan-out always wins, the writer drains only in rd_req-low cycles
    always_ff @(posedge clk or negedge rest_n) begin
        if (!rest_n)
            state_q <= IDLE;
        else
            state_q <= grant;
    end

    // next grant decided fresh every cycle, no hold-over between requesters
    always_comb begin
        grant = rd_req ? RD : pending ? WR : IDLE;
    end

    // hold the scan-out address alongside the RD grant so it reaches the RAM one edge later
    always_ff @(posedge clk or negedge rest_n) begin
        if (!rest_n)
            rd_addr_q <= '0;
        else if (rd_req)
            rd_addr_q <= rd_addr;
    end

    // RAM command register driven from the registered grant; IDLE keeps address and data stable
    always_ff @(posedge clk or negedge rest_n) begin
        if (!rest_n) begin
            ram_addr <= '0;
            ram_we   <= 1'b0;
            ram_wdat <= '0;
        end else begin
            ram_we <= state_q == WR;
            if (state_q == RD) begin
                ram_addr <= rd_addr_q;
            end else if (state_q == WR) begin
                ram_addr <= head_addr;
                ram_wdat <= head_data;
            end
        end
    end

    // read return pipeline: command edge, RAM access edge, then capture into rd_data
    always_ff @(posedge clk or negedge rest_n) begin
        if (!rest_n) begin
            rd_pipe  <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_pipe  <= {rd_pipe[RD_LAT-3:0], state_q == RD};
            rd_valid <= rd_pipe[RD_LAT-2];
            if (rd_pipe[RD_LAT-2])
                rd_data <= ram_rdat;
        end
    end

`ifdef LCD_FB_ARB_STAT_EN
    // count cycles where the writer is held off, sticking at all-ones
    always_ff @(posedge clk or negedge rest_n) begin
        if (!rest_n)
            wr_stall_cnt <= '0;
        else if (wr_valid && !wr_ready && wr_stall_cnt != 16'hFFFF)
            wr_stall_cnt <= wr_stall_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_lcd_fb_arbiter.sv
// tb_lcd_fb_arbiter: table vectors, directed corner sequences and random traffic against a queue-level model
module tb_lcd_fb_arbiter;

    localparam int D = 8;
    localparam int OP_NONE = 0;
    localparam int OP_RD   = 1;
    localparam int OP_WR   = 2;

    logic        clk = 1'b0;
    logic        rest_n = 1'b0;
    logic        rd_req = 1'b0;
    logic [15:0] rd_addr = '0;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [15:0] wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic [15:0] ram_addr;
    logic        ram_we;
    logic [15:0] ram_wdat;
    logic [15:0] ram_rdat = '0;
`ifdef LCD_FB_ARB_STAT_EN
    logic [15:0] wr_stall_cnt;
    int          e_stall = 0;
`endif

    lcd_fb_arbiter #(.AW(16), .DW(16), .WFIFO_DEPTH(D)) dut (
        .clk      (clk),
        .rest_n   (rest_n),
        .rd_req   (rd_req),
        .rd_addr  (rd_addr),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .ram_addr (ram_addr),
        .ram_we   (ram_we),
        .ram_wdat (ram_wdat),
        .ram_rdat (ram_rdat)
`ifdef LCD_FB_ARB_STAT_EN
        ,
        .wr_stall_cnt (wr_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // external single-port RAM: read-before-write, one-cycle read latency
    logic [15:0] mem [0:65535];
    always @(posedge clk) begin
        if (ram_we)
            mem[ram_addr] <= ram_wdat;
        ram_rdat <= mem[ram_addr];
    end

    // reference model: RAM operations take effect in grant order; a read returns its value 3 edges after the grant
    typedef struct { logic [15:0] a; logic [15:0] d; } wr_t;
    typedef struct { int due; logic [15:0] d; } rd_t;
    logic [15:0] shadow [0:65535];
    wr_t  q[$];
    rd_t  rq[$];
    wr_t  pw;
    int   pg = OP_NONE;
    int   cyc = 0;
    logic [15:0] pa = '0;
    logic acc;
    logic e_we = 0, e_rv = 0, e_rdy = 1;
    logic [15:0] e_addr = '0, e_wdat = '0, e_rd = '0;

    always @(posedge clk or negedge rest_n) begin
        if (!rest_n) begin
            q.delete();
            rq.delete();
            pg = OP_NONE;
            cyc = 0;
            e_we = 0; e_rv = 0; e_rdy = 1;
            e_addr = '0; e_wdat = '0; e_rd = '0;
`ifdef LCD_FB_ARB_STAT_EN
            e_stall = 0;
`endif
        end else begin
            acc = wr_valid && (q.size() + int'(pg == OP_WR) < D);
`ifdef LCD_FB_ARB_STAT_EN
            if (wr_valid && !acc && e_stall < 65535)
                e_stall++;
`endif
            e_we = 0;
            if (pg == OP_RD)
                e_addr = pa;
            else if (pg == OP_WR) begin
                e_we = 1; e_addr = pw.a; e_wdat = pw.d;
            end
            e_rv = 0;
            if (rq.size() > 0 && rq[0].due == cyc) begin
                e_rv = 1;
                e_rd = rq[0].d;
                void'(rq.pop_front());
            end
            if (rd_req) begin
                pg = OP_RD;
                pa = rd_addr;
                rq.push_back('{cyc + 3, shadow[rd_addr]});
            end else if (q.size() > 0) begin
                pg = OP_WR;
                pw = q.pop_front();
                shadow[pw.a] = pw.d;
            end else
                pg = OP_NONE;
            if (acc)
                q.push_back('{wr_addr, wr_data});
            e_rdy = (q.size() + int'(pg == OP_WR)) < D;
            cyc++;
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_check();
        chk("wr_ready", wr_ready, e_rdy);
        chk("ram_we", ram_we, e_we);
        chk("ram_addr", ram_addr, e_addr);
        if (e_we)
            chk("ram_wdat", ram_wdat, e_wdat);
        chk("rd_valid", rd_valid, e_rv);
        chk("rd_data", rd_data, e_rd);
`ifdef LCD_FB_ARB_STAT_EN
        chk("wr_stall_cnt", wr_stall_cnt, e_stall);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        model_check();
    endtask

    typedef struct {
        logic        rd_req;
        logic [15:0] rd_addr;
        logic        exp_rv;
        logic [15:0] exp_rd;
        logic [15:0] exp_ra;
    } vec_t;
    vec_t tbl [8];

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i]    = 16'(i) ^ 16'hA5A5;
            shadow[i] = 16'(i) ^ 16'hA5A5;
        end
        tbl[0] = '{1, 16'h0000, 0, 16'h0000, 16'h0000};
        tbl[1] = '{1, 16'h0001, 0, 16'h0000, 16'h0000};
        tbl[2] = '{1, 16'h0002, 0, 16'h0000, 16'h0001};
        tbl[3] = '{1, 16'h0003, 1, 16'hA5A5, 16'h0002};
        tbl[4] = '{0, 16'h0000, 1, 16'hA5A4, 16'h0003};
        tbl[5] = '{0, 16'h0000, 1, 16'hA5A7, 16'h0003};
        tbl[6] = '{0, 16'h0000, 1, 16'hA5A6, 16'h0003};
        tbl[7] = '{0, 16'h0000, 0, 16'hA5A6, 16'h0003};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {rd_valid, rd_data, ram_addr, ram_we, ram_wdat, wr_ready}, 51'd1);
        rest_n = 1'b1;

        // idle after reset
        repeat (20) tick();
        chk("idle_outputs", {rd_valid, rd_data, ram_addr, ram_we, ram_wdat, wr_ready}, 51'd1);

        // table: 4 back-to-back reads, 3-cycle latency
        for (int i = 0; i < 8; i++) begin
            rd_req  = tbl[i].rd_req;
            rd_addr = tbl[i].rd_addr;
            tick();
            chk("tbl_rd_valid", rd_valid, tbl[i].exp_rv);
            chk("tbl_rd_data", rd_data, tbl[i].exp_rd);
            chk("tbl_ram_addr", ram_addr, tbl[i].exp_ra);
        end

        // fill the FIFO while scan-out holds the RAM
        rd_req = 1; rd_addr = 16'h0200;
        for (int i = 0; i < 8; i++) begin
            wr_valid = 1; wr_addr = 16'h0100 + 16'(i); wr_data = 16'h1000 + 16'(i);
            tick();
            chk("fill_no_we", ram_we, 1'b0);
        end
        chk("full_not_ready", wr_ready, 1'b0);
        wr_addr = 16'h0108; wr_data = 16'h1008;
        repeat (3) begin
            tick();
            chk("stall_not_ready", wr_ready, 1'b0);
            chk("stall_no_we", ram_we, 1'b0);
        end
        wr_valid = 0; rd_req = 0;
        tick();
        chk("grant_edge_ready", wr_ready, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("drain_we", ram_we, 1'b1);
            chk("drain_addr", ram_addr, 16'h0100 + 16'(i));
            chk("drain_wdat", ram_wdat, 16'h1000 + 16'(i));
            if (i == 0)
                chk("ready_after_pop", wr_ready, 1'b1);
        end
        tick();
        chk("drain_done", ram_we, 1'b0);
        repeat (4) tick();

        // alternating scan-out with 3 queued writes
        rd_req = 1; rd_addr = 16'h0301;
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1; wr_addr = 16'h0300 + 16'(i); wr_data = 16'hBEE0 + 16'(i);
            tick();
        end
        wr_valid = 0;
        for (int i = 0; i < 16; i++) begin
            rd_req = (i % 2) == 0;
            rd_addr = 16'h0300 + 16'(i % 4);
            tick();
        end
        rd_req = 0;
        repeat (6) tick();

        // reset with writes queued and reads in flight
        rd_req = 1; rd_addr = 16'h0010;
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1; wr_addr = 16'h0500 + 16'(i); wr_data = 16'hC000 + 16'(i);
            tick();
        end
        #2 rest_n = 0;
        rd_req = 0; wr_valid = 0;
        @(posedge clk);
        @(negedge clk);
        chk("midreset_outputs", {rd_valid, rd_data, ram_addr, ram_we, ram_wdat, wr_ready}, 51'd1);
        rest_n = 1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("post_reset_no_rv", rd_valid, 1'b0);
            chk("post_reset_no_we", ram_we, 1'b0);
        end

        // random traffic in phases of differing read density
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 800; i++) begin
                rd_req   = $urandom_range(0, 99) < 30 + p * 15;
                rd_addr  = 16'h0400 + 16'($urandom_range(0, 15));
                wr_valid = $urandom_range(0, 99) < 60;
                wr_addr  = 16'h0400 + 16'($urandom_range(0, 15));
                wr_data  = 16'($urandom);
                tick();
            end
        end
        rd_req = 0; wr_valid = 0;
        repeat (12) tick();

`ifdef LCD_FB_ARB_STAT_EN
        // hold the FIFO full with the writer pushing until the stall counter saturates
        rd_req = 1; rd_addr = 16'h0000; wr_valid = 1; wr_addr = 16'h0600; wr_data = 16'h5555;
        repeat (70000) @(negedge clk);
        model_check();
        chk("stall_saturated", wr_stall_cnt, 16'hFFFF);
        rd_req = 0; wr_valid = 0;
        repeat (12) tick();
        chk("stall_holds", wr_stall_cnt, 16'hFFFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
